// File: rtl/program_sequencer.sv
// Program sequencer: computes the next program-memory address and holds the PC.
// Define PS_CALL_STACK_EN to add the 4-deep return-address stack with sticky overflow/underflow flags.
module program_sequencer (
    input  logic       clk,
    input  logic       async_reset_n,
    input  logic       jump,
    input  logic       conditional_jump,
    input  logic       call,
    input  logic       ret,
    input  logic [3:0] LS_nibble_ir,
    input  logic       zero_flag,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic       stack_ovf,
    output logic       stack_unf,
    output logic [7:0] from_PS
);

    logic [7:0] target;
    logic [7:0] pc_inc;

    assign target  = {LS_nibble_ir, 4'h0};
    assign pc_inc  = pc + 8'd1;
    assign from_PS = pc;

`ifdef PS_CALL_STACK_EN
    logic [7:0] stack [4];
    logic [2:0] sp;
    logic [1:0] top_idx;
    logic       jump_taken;
    logic       do_call;
    logic       do_ret;

    // A strobe only has side effects when nothing of higher priority is active.
    assign jump_taken = jump || (conditional_jump && !zero_flag);
    assign do_call    = !jump_taken && call;
    assign do_ret     = !jump_taken && !call && ret;
    assign top_idx    = sp[1:0] - 2'd1;

    always_comb begin
        pm_addr = pc_inc;
        if (!async_reset_n)
            pm_addr = 8'h00;
        else if (jump_taken || call)
            pm_addr = target;
        else if (ret && (sp != 3'd0))
            pm_addr = stack[top_idx];
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sp        <= 3'd0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            for (int i = 0; i < 4; i++)
                stack[i] <= 8'h00;
        end else if (do_call) begin
            if (sp != 3'd4) begin
                stack[sp[1:0]] <= pc_inc;
                sp             <= sp + 3'd1;
            end else begin
                stack_ovf <= 1'b1;
            end
        end else if (do_ret) begin
            if (sp != 3'd0)
                sp <= sp - 3'd1;
            else
                stack_unf <= 1'b1;
        end
    end
`else
    // Without the stack a call degenerates to a jump and a return to a plain increment.
    always_comb begin
        pm_addr = pc_inc;
        if (!async_reset_n)
            pm_addr = 8'h00;
        else if (jump || (conditional_jump && !zero_flag) || call)
            pm_addr = target;
        else if (ret)
            pm_addr = pc_inc;
    end

    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n)
            pc <= 8'h00;
        else
            pc <= pm_addr;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have the port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have the port: async_reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have the port: jump  input  1  unconditional jump strobe from the instruction decoder.
REQ-004 SHALL have the port: conditional_jump  input  1  jump-if-not-zero strobe from the instruction decoder.
REQ-005 SHALL have the port: call  input  1  subroutine call strobe.
REQ-006 SHALL have the port: ret  input  1  subroutine return strobe.
REQ-007 SHALL have the port: LS_nibble_ir  input  4  jump/call target field from the instruction register.
REQ-008 SHALL have the port: zero_flag  input  1  r_eq_0 from the computational unit.
REQ-009 SHALL have the port: pm_addr  output  8  next program-memory address (combinational).
REQ-010 SHALL have the port: pc  output  8  registered current program counter.
REQ-011 SHALL have the port: stack_ovf  output  1  sticky call-stack overflow flag.
REQ-012 SHALL have the port: stack_unf  output  1  sticky call-stack underflow flag.
REQ-013 SHALL have the port: from_PS  output  8  debug bus, equal to pc.

Function
REQ-014 SHALL compute target = {LS_nibble_ir, 4'h0}.
REQ-015 SHALL select pm_addr with this strict priority:
- async_reset_n low -> 8'h00.
- jump -> target.
- conditional_jump && !zero_flag -> target.
- call -> target.
- ret -> popped address.
- otherwise -> pc + 1.
REQ-016 SHALL treat conditional_jump with zero_flag=1 as pc + 1.
REQ-017 SHALL wrap pc + 1 modulo 256, so 8'hFF -> 8'h00.
REQ-018 SHALL load pc <= pm_addr on every rising clk edge: one-cycle latency, no stall.
REQ-019 SHALL, when several strobes are high together, act only on the highest-priority one. Lower-priority strobes SHALL have no side effect; in particular there is no push or pop.
REQ-020 SHALL implement a 4-entry LIFO of 8-bit return addresses with a 3-bit depth counter sp (0..4).
REQ-021 SHALL, on call with sp<4, push pc + 1 (wrapped) and increment sp.
REQ-022 SHALL, on call with sp==4, still jump to target, discard the push, leave sp unchanged and set stack_ovf.
REQ-023 SHALL, on ret with sp>0, drive pm_addr = the top entry and decrement sp.
REQ-024 SHALL, on ret with sp==0, drive pm_addr = pc + 1, leave sp unchanged and set stack_unf.
REQ-025 SHALL keep stack_ovf and stack_unf set until reset.

Reset
REQ-026 SHALL, while async_reset_n is low, force pc, sp, every stack entry, stack_ovf and stack_unf to 0 asynchronously.
REQ-027 SHALL hold pm_addr at 8'h00 while async_reset_n is low, so the instruction at address 0 is fetched during reset.
REQ-028 SHALL make pm_addr = 8'h01 on the first cycle after reset deassertion when no strobe is active.
REQ-029 SHALL discard all pending stack contents on reset mid-subroutine; a subsequent ret SHALL underflow.

Configuration
REQ-030 SHALL include the stack logic and the stack_ovf/stack_unf behaviour of REQ-020..REQ-025 when PS_CALL_STACK_EN is defined.
REQ-031 SHALL, without PS_CALL_STACK_EN:
- treat call as jump to target with no push;
- treat ret as pc + 1;
- tie stack_ovf and stack_unf to 0;
- instantiate no stack storage.

Verification
REQ-032 Bench SHALL check reset: hold async_reset_n=0 mid-count at pc=8'h37 -> pc=8'h00 and pm_addr=8'h00 immediately; release -> pc sequence 00,01,02.
REQ-033 Bench SHALL check conditional jump: conditional_jump=1, LS_nibble_ir=4'hA, zero_flag=0 -> next pc=8'hA0; repeat with zero_flag=1 -> next pc = old pc + 1.
REQ-034 Bench SHALL check nesting at pc=8'h12 (with PS_CALL_STACK_EN):
- call to 4'h3 -> pc=8'h30;
- call to 4'h5 -> pc=8'h50;
- ret -> pc=8'h31;
- ret -> pc=8'h13.
REQ-035 Bench SHALL check overflow: five consecutive calls -> stack_ovf=1 after the fifth; four rets return correctly; a fifth ret -> pc+1 and stack_unf=1.
REQ-036 Bench SHALL check priority and wrap: jump=1 with call=1 and ret=1 -> target taken and sp unchanged; free-run from pc=8'hFF -> pc=8'h00.
REQ-037 Bench SHALL check the build without PS_CALL_STACK_EN: call to 4'h4 from 8'h20 -> pc=8'h40; ret -> pc=8'h41; stack_ovf and stack_unf stay 0.
